dcache_ctrl: RTL and testbench

- Blocking controller for a direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's load/store port and the external memory port.
- Read hits return data combinationally with no stall. Read misses refill a full line in word beats while the core is stalled. Every store is written through to memory while the core is stalled.
- Sits between the decoder-driven MemRead/MemWrite/ALU-address signals and the data-memory interface.

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_storage.sv | 67 ++++++
 rtl/dcache_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the dcache_ctrl data-cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        WDONE  = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam int DEF_BUS_WIDTH  = 32;
    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int calc_ofs_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int bus_width, input int num_lines, input int line_words);
        return bus_width - WORD_SHIFT - calc_ofs_w(line_words) - calc_idx_w(num_lines);
    endfunction

    localparam int OFS_W = calc_ofs_w(DEF_LINE_WORDS);
    localparam int IDX_W = calc_idx_w(DEF_NUM_LINES);
    localparam int TAG_W = calc_tag_w(DEF_BUS_WIDTH, DEF_NUM_LINES, DEF_LINE_WORDS);

endpackage

// File: rtl/dcache_storage.sv
// Valid/tag/data arrays of the direct-mapped cache: async-clear valid bits,
// combinational read, one write port (word write and/or tag+valid set on one line).
module dcache_storage
    import dcache_pkg::*;
#(
    parameter  int BUS_WIDTH  = 32,
    parameter  int NUM_LINES  = 16,
    parameter  int LINE_WORDS = 4,
    localparam int OFS_BITS   = calc_ofs_w(LINE_WORDS),
    localparam int CNT_BITS   = (OFS_BITS > 0) ? OFS_BITS : 1,
    localparam int IDX_BITS   = calc_idx_w(NUM_LINES),
    localparam int TAG_BITS   = calc_tag_w(BUS_WIDTH, NUM_LINES, LINE_WORDS)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_BITS-1:0]  rd_idx,
    input  logic [CNT_BITS-1:0]  rd_ofs,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [BUS_WIDTH-1:0] rd_data,
    input  logic                 wr_word_en,
    input  logic                 wr_line_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [CNT_BITS-1:0]  wr_ofs,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic [TAG_BITS-1:0]  wr_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_BITS-1:0]  tag_mem_q  [NUM_LINES];
    logic [BUS_WIDTH-1:0] data_mem_q [NUM_LINES][LINE_WORDS];

    // Next valid vector: a line becomes valid only when its refill completes.
    always_comb begin
        valid_d = valid_q;
        if (wr_line_en) begin
            valid_d[wr_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays hold no reset value.
    always_ff @(posedge clk) begin
        if (wr_line_en) begin
            tag_mem_q[wr_idx] <= wr_tag;
        end
        if (wr_word_en) begin
            data_mem_q[wr_idx][wr_ofs] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem_q[rd_idx];
    assign rd_data  = data_mem_q[rd_idx][rd_ofs];

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (o_HitCnt, o_MissCnt).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int BUS_WIDTH  = 32,
    parameter  int NUM_LINES  = 16,
    parameter  int LINE_WORDS = 4
)(
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic [BUS_WIDTH-1:0] i_Addr,
    input  logic [BUS_WIDTH-1:0] i_WrData,
    output logic [BUS_WIDTH-1:0] o_RdData,
    output logic                 o_Stall,
    output logic                 o_MemReq,
    output logic                 o_MemWe,
    output logic [BUS_WIDTH-1:0] o_MemAddr,
    output logic [BUS_WIDTH-1:0] o_MemWrData,
    input  logic                 i_MemAck,
    input  logic [BUS_WIDTH-1:0] i_MemRdData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          o_HitCnt,
    output logic [31:0]          o_MissCnt
`endif
);

    localparam int OFS_BITS = calc_ofs_w(LINE_WORDS);
    localparam int CNT_BITS = (OFS_BITS > 0) ? OFS_BITS : 1;
    localparam int IDX_BITS = calc_idx_w(NUM_LINES);
    localparam int TAG_BITS = calc_tag_w(BUS_WIDTH, NUM_LINES, LINE_WORDS);

    function automatic logic [CNT_BITS-1:0] addr_ofs(input logic [BUS_WIDTH-1:0] a);
        return CNT_BITS'((a >> WORD_SHIFT) & BUS_WIDTH'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IDX_BITS-1:0] addr_idx(input logic [BUS_WIDTH-1:0] a);
        return IDX_BITS'((a >> (WORD_SHIFT + OFS_BITS)) & BUS_WIDTH'(NUM_LINES - 1));
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [BUS_WIDTH-1:0] a);
        return TAG_BITS'(a >> (WORD_SHIFT + OFS_BITS + IDX_BITS));
    endfunction

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BUS_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;

    logic                 rd_valid_s;
    logic [TAG_BITS-1:0]  rd_tag_s;
    logic [BUS_WIDTH-1:0] rd_data_s;
    logic                 hit_s;
    logic                 ack_s;
    logic                 stall_s;
    logic                 hit_rd_s;
    logic                 wr_word_en_s;
    logic                 wr_line_en_s;
    logic [IDX_BITS-1:0]  wr_idx_s;
    logic [CNT_BITS-1:0]  wr_ofs_s;
    logic [BUS_WIDTH-1:0] wr_data_s;

    dcache_storage #(
        .BUS_WIDTH  (BUS_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_storage (
        .clk        (i_Clk),
        .rst_n      (i_Rst_n),
        .rd_idx     (addr_idx(i_Addr)),
        .rd_ofs     (addr_ofs(i_Addr)),
        .rd_valid   (rd_valid_s),
        .rd_tag     (rd_tag_s),
        .rd_data    (rd_data_s),
        .wr_word_en (wr_word_en_s),
        .wr_line_en (wr_line_en_s),
        .wr_idx     (wr_idx_s),
        .wr_ofs     (wr_ofs_s),
        .wr_data    (wr_data_s),
        .wr_tag     (addr_tag(mem_addr_q))
    );

    assign hit_s = rd_valid_s & (rd_tag_s == addr_tag(i_Addr));
    // A stray ack with no outstanding beat must not advance anything.
    assign ack_s = i_MemAck & mem_req_q;

    // Next-state, memory-port and array-write decode.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        cnt_d         = cnt_q;
        stall_s       = 1'b0;
        hit_rd_s      = 1'b0;
        wr_word_en_s  = 1'b0;
        wr_line_en_s  = 1'b0;
        wr_idx_s      = addr_idx(i_Addr);
        wr_ofs_s      = addr_ofs(i_Addr);
        wr_data_s     = i_WrData;
        case (state_q)
            IDLE: begin
                if (i_MemWrite) begin
                    stall_s       = 1'b1;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = i_Addr & ~BUS_WIDTH'(WORD_BYTES - 1);
                    mem_wr_data_d = i_WrData;
                    wr_word_en_s  = hit_s;
                    state_d       = WRITE;
                end else if (i_MemRead) begin
                    if (hit_s) begin
                        hit_rd_s = 1'b1;
                    end else begin
                        stall_s    = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_Addr & ~BUS_WIDTH'(WORD_BYTES * LINE_WORDS - 1);
                        cnt_d      = '0;
                        state_d    = REFILL;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            REFILL: begin
                stall_s   = 1'b1;
                wr_idx_s  = addr_idx(mem_addr_q);
                wr_ofs_s  = cnt_q;
                wr_data_s = i_MemRdData;
                if (ack_s) begin
                    wr_word_en_s = 1'b1;
                    cnt_d        = cnt_q + CNT_BITS'(1);
                    mem_addr_d   = mem_addr_q + BUS_WIDTH'(WORD_BYTES);
                    if (cnt_q == CNT_BITS'(LINE_WORDS - 1)) begin
                        mem_req_d    = 1'b0;
                        wr_line_en_s = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end else begin
                    wr_word_en_s = 1'b0;
                end
            end
            WRITE: begin
                stall_s = 1'b1;
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = WDONE;
                end else begin
                    state_d = WRITE;
                end
            end
            WDONE: begin
                // One unstalled cycle lets the core retire the store before requests are sampled again.
                stall_s = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Controller state and registered memory-port outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_Stall     = stall_s & i_Rst_n;
    assign o_RdData    = rd_data_s;
    assign o_MemReq    = mem_req_q;
    assign o_MemWe     = mem_we_q;
    assign o_MemAddr   = mem_addr_q;
    assign o_MemWrData = mem_wr_data_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        filled_q, filled_d;

    // Saturating counters; the load that completes right after its own refill is not a fresh hit.
    always_comb begin
        filled_d = (state_q == REFILL) && (state_d == IDLE);
        if (hit_rd_s && !filled_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == IDLE) && (state_d == REFILL) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            filled_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            filled_q   <= filled_d;
        end
    end

    assign o_HitCnt  = hit_cnt_q;
    assign o_MissCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed plan steps, then random loads/stores
// against a line-presence model and a word-addressed memory model.
module tb_dcache_ctrl;

    localparam int NL = 16;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_ack;
    logic [31:0] mem_rd_data;

    logic        rsp_ack = 1'b0;
    logic        inj_ack = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    int          rsp_delay = 2;
    int          wait_cnt = 0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] mem [bit [31:0]];
    bit          model_valid [NL];
    logic [31:0] model_line  [NL];

    assign mem_ack     = rsp_ack | inj_ack;
    assign mem_rd_data = rsp_data;

    always #5 clk = ~clk;

    dcache_ctrl #(.BUS_WIDTH(32), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_MemRead   (mem_read),
        .i_MemWrite  (mem_write),
        .i_Addr      (addr),
        .i_WrData    (wr_data),
        .o_RdData    (rd_data),
        .o_Stall     (stall),
        .o_MemReq    (mem_req),
        .o_MemWe     (mem_we),
        .o_MemAddr   (mem_addr),
        .o_MemWrData (mem_wr_data),
        .i_MemAck    (mem_ack),
        .i_MemRdData (mem_rd_data)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: acks each beat rsp_delay cycles after it is presented, logs every beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_ack  <= 1'b0;
            wait_cnt <= 0;
        end else if (rsp_ack) begin
            rsp_ack  <= 1'b0;
            wait_cnt <= 1;
        end else if (mem_req) begin
            if (wait_cnt >= rsp_delay - 1) begin
                rsp_ack  <= 1'b1;
                rsp_data <= mem_rd(mem_addr);
                beats.push_back({mem_we, mem_addr, mem_wr_data});
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] a);
        logic [31:0] aw, base;
        int          idx, n0, cyc;
        bit          exp_hit;
        logic        prev_ack;
        aw      = a & 32'hFFFF_FFFC;
        base    = a & 32'hFFFF_FFF0;
        idx     = int'((a >> 4) & 32'(NL - 1));
        exp_hit = model_valid[idx] && (model_line[idx] == base);
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; addr = a;
        n0 = beats.size();
        @(negedge clk); #1;
        chk("ld_stall_first", {31'd0, stall}, {31'd0, !exp_hit});
        if (!exp_hit) begin
            cyc = 0;
            prev_ack = 1'b0;
            while (stall && cyc < 300) begin
                prev_ack = mem_ack;
                @(negedge clk); #1;
                cyc++;
            end
            chk("ld_refill_done", {31'd0, stall}, 32'd0);
            chk("ld_stall_drop_after_last_ack", {31'd0, prev_ack}, 32'd1);
            chk("ld_refill_beats", beats.size() - n0, LW);
            for (int k = 0; k < LW; k++) begin
                if (n0 + k < beats.size()) begin
                    chk("ld_beat_addr", beats[n0 + k].addr, base + 32'(4 * k));
                    chk("ld_beat_we", {31'd0, beats[n0 + k].we}, 32'd0);
                end
            end
            model_valid[idx] = 1'b1;
            model_line[idx]  = base;
        end else begin
            chk("ld_hit_no_beat", beats.size() - n0, 0);
        end
        chk("ld_rd_data", rd_data, mem_rd(aw));
        chk("ld_req_idle", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit rd_too);
        logic [31:0] aw;
        int          n0, cyc;
        aw = a & 32'hFFFF_FFFC;
        @(posedge clk); #1;
        mem_write = 1'b1; mem_read = rd_too; addr = a; wr_data = d;
        n0 = beats.size();
        @(negedge clk); #1;
        chk("st_stall_first", {31'd0, stall}, 32'd1);
        cyc = 0;
        while (stall && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("st_wdone_stall_low", {31'd0, stall}, 32'd0);
        chk("st_beats", beats.size() - n0, 1);
        if (beats.size() > n0) begin
            chk("st_beat_we", {31'd0, beats[n0].we}, 32'd1);
            chk("st_beat_addr", beats[n0].addr, aw);
            chk("st_beat_data", beats[n0].data, d);
        end
        chk("st_req_dropped", {31'd0, mem_req}, 32'd0);
        mem[aw] = d;
        @(posedge clk); #1;
        mem_write = 1'b0; mem_read = 1'b0;
        @(negedge clk); #1;
        chk("st_no_reissue", beats.size() - n0, 1);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, cyc;
        logic [31:0] a;
        for (int i = 0; i < NL; i++) begin
            model_valid[i] = 1'b0;
            model_line[i]  = 32'd0;
        end
        // Reset with a load request held: no stall, port idle.
        mem_read = 1'b1; addr = 32'h40;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wr_data, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        rst_n = 1'b1;

        mem[32'h40] = 32'hA0; mem[32'h44] = 32'hA1;
        mem[32'h48] = 32'hA2; mem[32'h4C] = 32'hA3;
        rsp_delay = 2;

        do_load(32'h40);
        do_load(32'h48);
        do_store(32'h44, 32'hDEAD_BEEF, 1'b0);
        do_load(32'h44);
        do_store(32'h1000, 32'h1234_5678, 1'b0);
        do_load(32'h1000);
        do_load(32'h40);
        do_load(32'h440);
        do_load(32'h40);
        do_store(32'h48, 32'h55AA_33CC, 1'b1);
        do_load(32'h48);

        // Reset in the middle of a refill of 0x440 (currently evicted).
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h440;
        n0 = beats.size();
        cyc = 0;
        while ((beats.size() - n0) < 2 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("mid_refill_two_beats", beats.size() - n0, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < NL; i++) model_valid[i] = 1'b0;
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        inj_ack = 1'b1;
        @(posedge clk); #1;
        inj_ack = 1'b0;
        @(negedge clk); #1;
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        do_load(32'h40);
        do_load(32'h440);

        // Random traffic over a few indices and tags to force hits, misses and evictions.
        for (int n = 0; n < 120; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rsp_delay = int'($urandom_range(1, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: do_load(a);
                6, 7, 8:          do_store(a, $urandom, 1'b0);
                default: begin
                    @(posedge clk); #1;
                    @(negedge clk); #1;
                    chk("idle_stall", {31'd0, stall}, 32'd0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
